// File: rtl/ifetch_prefetch.sv
// Instruction fetch/prefetch stage: one outstanding memory read,
// small FIFO of {pc, instr}, redirect flushes and restarts fetch.
module ifetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         mem_req_o,
  output logic [15:0]                  mem_addr_o,
  input  logic                         mem_ack_i,
  input  logic [15:0]                  mem_rdata_i,
  output logic                         instr_valid_o,
  output logic [15:0]                  instr_o,
  output logic [15:0]                  instr_pc_o,
  input  logic                         instr_ready_i,
  input  logic                         redirect_i,
  input  logic [15:0]                  redirect_pc_i,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e          state_q;
  logic [15:0]     fetch_pc_q;
  logic [15:0]     drop_addr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [15:0]     pc_mem_q  [DEPTH];
  logic [15:0]     ins_mem_q [DEPTH];

  logic            push;
  logic            pop;
  logic [CW-1:0]   cnt_pop;
  logic [CW-1:0]   count_d;
  logic            space;
  logic            room;

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = ins_mem_q[rd_ptr_q];
  assign instr_pc_o    = pc_mem_q[rd_ptr_q];
  assign fifo_count_o  = count_q;

  assign mem_req_o  = (state_q == REQ) || (state_q == DROP);
  assign mem_addr_o = (state_q == DROP) ? drop_addr_q : fetch_pc_q;

  assign pop     = instr_valid_o && instr_ready_i && !redirect_i;
  assign push    = (state_q == REQ) && mem_ack_i && !redirect_i;
  assign cnt_pop = count_q - CW'(pop);
  assign count_d = cnt_pop + CW'(push);
  // Reserving a slot before issuing keeps an acked word from overflowing
  assign space   = (cnt_pop < FULL);
  assign room    = (count_d < FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      if (redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
          ins_mem_q[wr_ptr_q] <= mem_rdata_i;
          wr_ptr_q            <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_d;
      end

      unique case (state_q)
        IDLE: begin
          if (redirect_i) fetch_pc_q <= redirect_pc_i;
          else if (space) state_q <= REQ;
        end
        REQ: begin
          if (redirect_i) begin
            fetch_pc_q <= redirect_pc_i;
            if (mem_ack_i) begin
              state_q <= IDLE;
            end else begin
              state_q     <= DROP;
              drop_addr_q <= fetch_pc_q;
            end
          end else if (mem_ack_i) begin
            fetch_pc_q <= fetch_pc_q + 16'd1;
            state_q    <= room ? REQ : IDLE;
          end
        end
        DROP: begin
          if (redirect_i) fetch_pc_q <= redirect_pc_i;
          if (mem_ack_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Random stimulus for ifetch_prefetch with a stream-level reference
// model: expected words queued on ack, popped by a separate monitor.
module tb_ifetch_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0000;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req;
  logic [15:0]   mem_addr;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_rdata = '0;
  logic          instr_valid;
  logic [15:0]   instr;
  logic [15:0]   instr_pc;
  logic          instr_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [15:0]   redirect_pc = '0;
  logic [CW-1:0] fifo_count;

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .instr_valid_o(instr_valid),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc),
    .instr_ready_i(instr_ready),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] d;
  } item_t;

  item_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    n_pop = 0;
  bit    started = 1'b0;

  function automatic logic [15:0] hashw(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: consumes the DUT output stream and checks occupancy
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (started && !reset) begin
        chk("count_vs_model", 32'(fifo_count), 32'(sb.size()));
        chk("valid_vs_count", 32'(instr_valid), 32'(fifo_count != '0));
        if (fifo_count == CW'(DEPTH))
          chk("full_no_req", 32'(mem_req), 32'd0);
        if (instr_valid && instr_ready && !redirect) begin
          if (sb.size() == 0) begin
            chk("pop_nonempty", 32'd0, 32'd1);
          end else begin
            it = sb.pop_front();
            chk("instr_pc", 32'(instr_pc), 32'(it.pc));
            chk("instr", 32'(instr), 32'(it.d));
            n_pop++;
          end
        end
      end
    end
  end

  // Driver + memory model + expected-stream producer
  initial begin
    logic [15:0] exp_fetch;
    logic [15:0] stale_addr;
    logic [15:0] prev_addr;
    bit          stale, wait_act, prev_req, prev_ack;
    bit          pend_push, pend_flush, ack, redir, push, was_stale;
    int          wait_cnt, lat_max, rdy_pct, red_pct, pops0, sel;
    item_t       pend_it;

    exp_fetch = RPC; stale_addr = '0; prev_addr = '0;
    stale = 0; wait_act = 0; prev_req = 0; prev_ack = 0;
    pend_push = 0; pend_flush = 0; wait_cnt = 0; pend_it = '0;

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'(RPC));
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    started = 1'b1;

    for (int i = 0; i < 3200; i++) begin
      @(posedge clk); #1;
      if (pend_flush) sb.delete();
      if (pend_push) sb.push_back(pend_it);
      pend_flush = 0; pend_push = 0;

      if (prev_req && !prev_ack) begin
        chk("req_held", 32'(mem_req), 32'd1);
        chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
      end

      if (i == 1500) begin
        mem_ack = 0; redirect = 0; instr_ready = 0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'(RPC));
        sb.delete();
        exp_fetch = RPC; stale = 0; wait_act = 0;
        prev_req = 0; prev_ack = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        continue;
      end

      if (i < 40) begin
        lat_max = 0; rdy_pct = 100; red_pct = 0;
      end else if (i < 60) begin
        lat_max = 0; rdy_pct = 0; red_pct = 0;
      end else if (i < 3050) begin
        lat_max = 3; rdy_pct = 70; red_pct = 5;
      end else begin
        lat_max = 0; rdy_pct = 100; red_pct = 0;
      end
      if (i == 3050) pops0 = n_pop;

      redir = ($urandom_range(0, 99) < red_pct);
      sel = $urandom_range(0, 3);
      redirect_pc = (sel == 0) ? 16'hFFFE :
                    (sel == 1) ? 16'h0100 : 16'($urandom);
      redirect = redir;
      instr_ready = ($urandom_range(0, 99) < rdy_pct);

      ack = 0;
      if (mem_req) begin
        if (!wait_act) begin
          wait_cnt = $urandom_range(0, lat_max);
          wait_act = 1;
        end
        if (wait_cnt == 0) begin
          ack = 1; wait_act = 0;
        end else begin
          wait_cnt--;
        end
      end
      mem_ack = ack;
      mem_rdata = hashw(mem_addr);
      if (ack) begin
        if (stale) chk("drop_addr", 32'(mem_addr), 32'(stale_addr));
        else chk("fetch_addr", 32'(mem_addr), 32'(exp_fetch));
      end

      was_stale = stale;
      push = ack && !was_stale && !redir;
      if (ack) stale = 0;
      if (redir && mem_req && !ack) begin
        if (!was_stale) stale_addr = mem_addr;
        stale = 1;
      end
      if (push) begin
        pend_it = '{pc: exp_fetch, d: hashw(exp_fetch)};
        pend_push = 1;
        exp_fetch = exp_fetch + 16'd1;
      end
      if (redir) begin
        exp_fetch = redirect_pc;
        pend_flush = 1;
      end
      prev_req = mem_req; prev_ack = ack; prev_addr = mem_addr;
    end

    @(negedge clk);
    chk("drain_progress", 32'(n_pop - pops0 >= 100), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
